// File: rtl/vga_pkg.sv
// Shared timing defaults, register map and small helpers for the VGA frame counter core.
package vga_pkg;

  // Default 640x480 @ 60 Hz timing with a 100 MHz system clock.
  localparam int unsigned DEF_DIV = 4;
  localparam int unsigned DEF_HD  = 640;
  localparam int unsigned DEF_HF  = 16;
  localparam int unsigned DEF_HR  = 96;
  localparam int unsigned DEF_HB  = 48;
  localparam int unsigned DEF_VD  = 480;
  localparam int unsigned DEF_VF  = 10;
  localparam int unsigned DEF_VR  = 2;
  localparam int unsigned DEF_VB  = 33;
  localparam int unsigned DEF_HT  = DEF_HD + DEF_HF + DEF_HR + DEF_HB;
  localparam int unsigned DEF_VT  = DEF_VD + DEF_VF + DEF_VR + DEF_VB;

  localparam int unsigned CoordW = 11;
  typedef logic [CoordW-1:0] coord_t;

  typedef enum logic [1:0] {
    REG_FCNT = 2'd0,
    REG_POS  = 2'd1,
    REG_CTRL = 2'd2,
    REG_CLR  = 2'd3
  } reg_addr_e;

  // Layout of the low nibble returned by REG_CTRL.
  typedef struct packed {
    logic run;
    logic video_on;
    logic vsync;
    logic hsync;
  } ctrl_status_t;

  // True when lo <= v < lo + len.
  function automatic logic in_span(input coord_t v, input int unsigned lo,
                                   input int unsigned len);
    int unsigned vi;
    vi = 32'(v);
    return (vi >= lo) && (vi < lo + len);
  endfunction

endpackage

// File: rtl/vga_pixel_tick_gen.sv
// Mod-DIV clock divider producing a one-clk pixel enable; clr returns it to phase 0.
module vga_pixel_tick_gen
  import vga_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == Last);

endmodule

// File: rtl/vga_frame_counter_core.sv
// Raster timing generator: pixel tick, x/y, syncs, frame pulse and a small slot register set.
module vga_frame_counter_core
  import vga_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV,
  parameter int unsigned HD  = DEF_HD,
  parameter int unsigned HF  = DEF_HF,
  parameter int unsigned HR  = DEF_HR,
  parameter int unsigned HB  = DEF_HB,
  parameter int unsigned VD  = DEF_VD,
  parameter int unsigned VF  = DEF_VF,
  parameter int unsigned VR  = DEF_VR,
  parameter int unsigned VB  = DEF_VB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pixel_tick,
  output logic        frame_start
);

  localparam int unsigned HT = HD + HF + HR + HB;
  localparam int unsigned VT = VD + VF + VR + VB;
  localparam coord_t XLast = coord_t'(HT - 1);
  localparam coord_t YLast = coord_t'(VT - 1);

  logic         run_q, run_d;
  coord_t       x_q, x_d;
  coord_t       y_q, y_d;
  logic         hsync_q, hsync_d;
  logic         vsync_q, vsync_d;
  logic         video_on_q, video_on_d;
  logic [31:0]  fcnt_q, fcnt_d;

  logic         ctrl_wr, clr_wr, stop_wr, frame_end;
  ctrl_status_t status;

  // Reads have no side effects, so the read strobe and upper write bits carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{read, wr_data[31:1]};

  assign ctrl_wr = cs && write && (addr == REG_CTRL);
  assign clr_wr  = cs && write && (addr == REG_CLR);
  assign stop_wr = ctrl_wr && !wr_data[0];

  vga_pixel_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (stop_wr),
    .en    (run_q),
    .tick  (pixel_tick)
  );

  assign frame_end = pixel_tick && (x_q == XLast) && (y_q == YLast);

  always_comb begin
    run_d = run_q;
    if (ctrl_wr) begin
      run_d = wr_data[0];
    end
  end

  // Syncs are derived from next-state coordinates so they register alongside x/y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (stop_wr || !run_q) begin
      x_d = '0;
      y_d = '0;
    end else if (pixel_tick) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + coord_t'(1);
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
    hsync_d    = !in_span(x_d, HD + HF, HR);
    vsync_d    = !in_span(y_d, VD + VF, VR);
    video_on_d = (32'(x_d) < HD) && (32'(y_d) < VD);
  end

  // Clear beats a frame-end increment; a stop write in the frame-end cycle suppresses it.
  always_comb begin
    fcnt_d = fcnt_q;
    if (clr_wr) begin
      fcnt_d = '0;
    end else if (frame_end && !stop_wr) begin
      fcnt_d = fcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q      <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      run_q      <= run_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_comb begin
    status.run      = run_q;
    status.video_on = video_on_q;
    status.vsync    = vsync_q;
    status.hsync    = hsync_q;
  end

  always_comb begin
    rd_data = '0;
    if (cs) begin
      unique case (addr)
        REG_FCNT: rd_data = fcnt_q;
        REG_POS:  rd_data = {5'b0, y_q, 5'b0, x_q};
        REG_CTRL: rd_data = {28'b0, status};
        default:  rd_data = '0;
      endcase
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = pixel_tick && (x_q == '0) && (y_q == '0);

endmodule

// File: tb/tb_vga_frame_counter_core.sv
// Bench for vga_frame_counter_core using a reduced raster so whole frames fit in a short run.
module tb_vga_frame_counter_core;

  localparam int unsigned DIV = 4;
  localparam int unsigned HD = 16, HF = 2, HR = 4, HB = 3;
  localparam int unsigned VD = 8, VF = 2, VR = 2, VB = 3;
  localparam int unsigned HT = HD + HF + HR + HB;
  localparam int unsigned VT = VD + VF + VR + VB;
  localparam int unsigned FT = HT * VT;
  localparam int unsigned GUARD = 20000;

  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [1:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [10:0] x, y;
  logic        hsync, vsync, video_on, pixel_tick, frame_start;

  always #5 clk = ~clk;

  vga_frame_counter_core #(
    .DIV (DIV), .HD (HD), .HF (HF), .HR (HR), .HB (HB),
    .VD  (VD),  .VF (VF), .VR (VR), .VB (VB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .read        (read),
    .write       (write),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_tick  (pixel_tick),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        tick;
    logic        fs;
    logic [31:0] rd;
  } exp_t;

  typedef struct packed {
    logic        cs;
    logic [1:0]  addr;
    logic [31:0] rd;
    logic        tick;
    logic        fs;
  } vec_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_prints = 0;

  // Reference: clocks elapsed since the raster origin while running.
  int unsigned m_clk;
  bit          m_run;
  logic [31:0] m_fc;

  function automatic int unsigned mx();
    return (m_clk / DIV) % HT;
  endfunction

  function automatic int unsigned my();
    return ((m_clk / DIV) / HT) % VT;
  endfunction

  function automatic bit fe_pending();
    return m_run && (m_clk % DIV == DIV - 1) && ((m_clk / DIV) % FT == FT - 1);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int unsigned ex, ey;
    ex = mx();
    ey = my();
    e.x    = 11'(ex);
    e.y    = 11'(ey);
    e.hs   = !(ex >= HD + HF && ex < HD + HF + HR);
    e.vs   = !(ey >= VD + VF && ey < VD + VF + VR);
    e.von  = (ex < HD) && (ey < VD);
    e.tick = m_run && (m_clk % DIV == DIV - 1);
    e.fs   = e.tick && ex == 0 && ey == 0;
    e.rd   = '0;
    if (cs) begin
      case (addr)
        2'd0:    e.rd = m_fc;
        2'd1:    e.rd = {5'b0, 11'(ey), 5'b0, 11'(ex)};
        2'd2:    e.rd = {28'b0, m_run, e.von, e.vs, e.hs};
        default: e.rd = '0;
      endcase
    end
    return e;
  endfunction

  function automatic void model_edge();
    bit tk, fe, ctl, stop, clr;
    tk   = m_run && (m_clk % DIV == DIV - 1);
    fe   = tk && ((m_clk / DIV) % FT == FT - 1);
    ctl  = cs && write && addr == 2'd2;
    stop = ctl && !wr_data[0];
    clr  = cs && write && addr == 2'd3;
    if (!reset) begin
      m_clk = 0;
      m_fc  = '0;
      m_run = 1'b1;
    end else begin
      if (clr) m_fc = '0;
      else if (fe && !stop) m_fc = m_fc + 32'd1;
      if (stop) begin
        m_run = 1'b0;
        m_clk = 0;
      end else begin
        if (m_run) m_clk = m_clk + 1;
        if (ctl) m_run = 1'b1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    #1;
    sb.push_back(model_out());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    cs      = 1'($urandom_range(0, 1));
    read    = cs;
    write   = 1'b0;
    addr    = 2'($urandom_range(0, 3));
    wr_data = $urandom;
  endtask

  task automatic rd_reg(input logic [1:0] a);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; read = 1'b0; write = 1'b1; addr = a; wr_data = d;
    step();
    write = 1'b0;
  endtask

  task automatic guard_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: cycle budget of %0d expired, required condition never reached", name, GUARD);
  endtask

  task automatic run_until_pos(input int unsigned px, input int unsigned py,
                               input logic [31:0] fc, input string name);
    int unsigned g;
    g = 0;
    while (!(m_run && mx() == px && my() == py && m_clk % DIV == 1 && m_fc == fc)) begin
      drive_idle();
      step();
      g++;
      if (g > GUARD) begin
        guard_fail(name);
        break;
      end
    end
  endtask

  // Scoreboard: every stepped cycle is compared at the falling edge.
  always @(negedge clk) begin : mon
    exp_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {x, y, hsync, vsync, video_on, pixel_tick, frame_start, rd_data};
      if (cs && !read) a.rd = e.rd;
      n_tests++;
      if (a !== e) begin
        n_fail++;
        if (n_prints < 20) begin
          n_prints++;
          $display("FAIL sb_cycle @%0t: got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fs=%b rd=%h, expected x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fs=%b rd=%h",
                   $time, a.x, a.y, a.hs, a.vs, a.von, a.tick, a.fs, a.rd,
                   e.x, e.y, e.hs, e.vs, e.von, e.tick, e.fs, e.rd);
        end
      end
    end
  end

  initial begin
    vec_t tbl[8];
    int hs_low, first_x, last_x, vs_t, von_t, fs_n, tick_n, first_c, fs_at;
    int unsigned g;

    // Cycles just after reset release: raster at (0,0), then (1,0) from the 5th clk.
    tbl[0] = {1'b1, 2'd0, 32'h0, 1'b0, 1'b0};
    tbl[1] = {1'b1, 2'd1, 32'h0, 1'b0, 1'b0};
    tbl[2] = {1'b1, 2'd2, 32'hF, 1'b0, 1'b0};
    tbl[3] = {1'b0, 2'd2, 32'h0, 1'b1, 1'b1};
    tbl[4] = {1'b1, 2'd1, 32'h1, 1'b0, 1'b0};
    tbl[5] = {1'b1, 2'd3, 32'h0, 1'b0, 1'b0};
    tbl[6] = {1'b1, 2'd2, 32'hF, 1'b0, 1'b0};
    tbl[7] = {1'b1, 2'd0, 32'h0, 1'b1, 1'b0};

    reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    m_clk = 0; m_run = 1'b1; m_fc = '0;
    @(posedge clk);
    #1;
    step();
    step();
    check("reset_x", 32'(x), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    check("reset_syncs", {29'b0, hsync, vsync, video_on}, 32'h7);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cs = tbl[i].cs; read = tbl[i].cs; write = 1'b0; addr = tbl[i].addr;
      #1;
      check($sformatf("vec%0d_rd", i), rd_data, tbl[i].rd);
      check($sformatf("vec%0d_tick", i), 32'(pixel_tick), 32'(tbl[i].tick));
      check($sformatf("vec%0d_fs", i), 32'(frame_start), 32'(tbl[i].fs));
      step();
    end

    // First line: hsync low window aligned to x.
    hs_low = 0; first_x = -1; last_x = -1;
    for (int i = 0; i < int'(GUARD) && m_clk < HT * DIV; i++) begin
      drive_idle();
      #1;
      if (!hsync) begin
        hs_low++;
        if (first_x < 0) first_x = int'(x);
        last_x = int'(x);
      end
      step();
    end
    check("line_x", 32'(x), 32'd0);
    check("line_y", 32'(y), 32'd1);
    check("hsync_low_clks", 32'(hs_low), HR * DIV);
    check("hsync_first_x", 32'(first_x), HD + HF);
    check("hsync_last_x", 32'(last_x), HD + HF + HR - 1);

    for (int i = 0; i < int'(GUARD) && m_clk < FT * DIV; i++) begin
      drive_idle();
      step();
    end
    rd_reg(2'd0);
    check("frame1_count", rd_data, 32'd1);

    // One complete frame: pulse, vsync and display-area tick counts.
    vs_t = 0; von_t = 0; fs_n = 0;
    for (int i = 0; i < int'(GUARD) && m_clk < 2 * FT * DIV; i++) begin
      drive_idle();
      #1;
      if (pixel_tick && !vsync) vs_t++;
      if (pixel_tick && video_on) von_t++;
      if (frame_start) fs_n++;
      step();
    end
    check("frame_start_count", 32'(fs_n), 32'd1);
    check("vsync_low_ticks", 32'(vs_t), VR * HT);
    check("video_on_ticks", 32'(von_t), HD * VD);
    rd_reg(2'd0);
    check("frame2_count", rd_data, 32'd2);

    // Stop mid-line, stay idle, then resume from the origin.
    run_until_pos(10, 5, 32'd2, "reach_stop_pos");
    check("pre_stop_x", 32'(x), 32'd10);
    wr_reg(2'd2, 32'h0);
    cs = 1'b0; read = 1'b0;
    #1;
    check("stop_x", 32'(x), 32'd0);
    check("stop_y", 32'(y), 32'd0);
    tick_n = 0;
    for (int i = 0; i < 1000; i++) begin
      drive_idle();
      #1;
      if (pixel_tick || frame_start) tick_n++;
      step();
    end
    check("stopped_ticks", 32'(tick_n), 32'd0);
    rd_reg(2'd2);
    check("stopped_ctrl", rd_data, 32'h7);
    wr_reg(2'd2, 32'h1);
    first_c = -1; fs_at = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) rd_reg(2'd2);
      else drive_idle();
      #1;
      if (c == 0) check("resume_ctrl", rd_data, 32'hF);
      if (pixel_tick && first_c < 0) begin
        first_c = c;
        fs_at = int'(frame_start);
      end
      step();
    end
    check("resume_first_tick", 32'(first_c), DIV - 1);
    check("resume_frame_start", 32'(fs_at), 32'd1);
    g = 0;
    while (mx() != HD) begin
      drive_idle();
      step();
      g++;
      if (g > GUARD) begin
        guard_fail("reach_x_hd");
        break;
      end
    end
    rd_reg(2'd2);
    check("ctrl_blank", rd_data, 32'hB);

    // Clear in the exact frame-end cycle with frame_count = 7.
    g = 0;
    while (!(fe_pending() && m_fc == 32'd7)) begin
      drive_idle();
      step();
      g++;
      if (g > GUARD) begin
        guard_fail("reach_fc7_end");
        break;
      end
    end
    rd_reg(2'd0);
    check("fc_before_clear", rd_data, 32'd7);
    check("clear_cycle_tick", 32'(pixel_tick), 32'd1);
    wr_reg(2'd3, $urandom);
    rd_reg(2'd0);
    check("fc_after_clear", rd_data, 32'd0);
    check("wrap_x", 32'(x), 32'd0);

    // Stop write in the frame-end cycle suppresses the increment.
    g = 0;
    while (!fe_pending()) begin
      drive_idle();
      step();
      g++;
      if (g > GUARD) begin
        guard_fail("reach_frame_end");
        break;
      end
    end
    wr_reg(2'd2, 32'h0);
    rd_reg(2'd0);
    check("fc_stop_wins", rd_data, 32'd0);
    wr_reg(2'd2, 32'h1);

    // Single-clk reset mid-frame inside both sync pulses.
    run_until_pos(20, 10, 32'd1, "reach_reset_pos");
    rd_reg(2'd0);
    check("fc_before_reset", rd_data, 32'd1);
    check("pre_reset_syncs", {30'b0, hsync, vsync}, 32'h0);
    reset = 1'b0;
    drive_idle();
    step();
    reset = 1'b1;
    rd_reg(2'd1);
    check("post_reset_pos", rd_data, 32'd0);
    rd_reg(2'd0);
    check("post_reset_fc", rd_data, 32'd0);
    rd_reg(2'd2);
    check("post_reset_ctrl", rd_data, 32'hF);
    for (int i = 0; i < 12; i++) begin
      drive_idle();
      step();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_counter_core.md
Name: vga_frame_counter_core

Overview:
- Head of the video pipeline, directly upstream of the sprite/overlay cores.
- Generates the pixel-enable tick, the (x, y) raster coordinates, hsync/vsync/video_on and a frame-start pulse; the stream cores consume these.
- Exposes a small video-slot register set: run control, frame counter readback and clear, and position/status readback.

Parameters:
- DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz)
- HD, 640, horizontal display pixels
- HF, 16, horizontal front porch
- HR, 96, hsync pulse width
- HB, 48, horizontal back porch
- VD, 480, vertical display lines
- VF, 10, vertical front porch
- VR, 2, vsync pulse width
- VB, 33, vertical back porch

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- cs  in  1  slot select
- read  in  1  slot read strobe
- write  in  1  slot write strobe
- addr  in  2  register offset
- wr_data  in  32  write data
- rd_data  out  32  read data
- x  out  11  current pixel column
- y  out  11  current pixel line
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  (x,y) inside the display area
- pixel_tick  out  1  one-clk pixel enable
- frame_start  out  1  one-clk pulse at start of frame

Behaviour:
- Totals: HT = HD+HF+HR+HB (800); VT = VD+VF+VR+VB (525).
- Reset (reset==0 at a clk edge) sets the following:
  - div_cnt = 0, x = 0, y = 0, frame_count = 0, run = 1.
  - hsync = 1, vsync = 1, video_on = 1, pixel_tick = 0, frame_start = 0.
  - Reset mid-line is applied on the next edge with no partial update.
- Divider: div_cnt counts 0..DIV-1 while run = 1. pixel_tick = run && div_cnt == DIV-1, combinational.
- Counters advance only on pixel_tick:
  - If x == HT-1, x wraps to 0 and y advances; otherwise x increments.
  - y wraps from VT-1 to 0.
- Syncs and video_on are registered and computed from next-state x/y, so they change in the same cycle as x/y (zero skew):
  - hsync = 0 iff HD+HF <= x <= HD+HF+HR-1 (656..751).
  - vsync = 0 iff VD+VF <= y <= VD+VF+VR-1 (490..491).
  - video_on = x < HD && y < VD.
- frame_start = pixel_tick && x == 0 && y == 0, combinational.
- frame_count (32 bit) increments on pixel_tick when x == HT-1 && y == VT-1, and wraps modulo 2^32.
- Register map (reads are combinational, side-effect free; writes need cs && write):
  - 0: read frame_count.
  - 1: read {5'b0, y[10:0], 5'b0, x[10:0]}.
  - 2: read {28'b0, run, video_on, vsync, hsync}; write run = wr_data[0].
  - 3: write with any data clears frame_count.
- Run = 0 (written):
  - Next edge forces div_cnt = x = y = 0, hsync = vsync = 1, video_on = 1.
  - Counters hold; pixel_tick and frame_start stay 0.
  - Writing run = 1 resumes from (0,0); first tick after DIV clks, and it raises frame_start.
- Simultaneous events:
  - Clear (reg 3) and a frame-end increment in the same cycle -> frame_count = 0.
  - Run = 0 write and a frame-end tick in the same cycle -> stop wins and the increment is suppressed.
- rd_data = 0 when cs == 0.

Decomposition:
- Package vga_pkg holds:
  - default 640x480 timing constants (HD..VB, HT, VT);
  - register offsets REG_FCNT = 0, REG_POS = 1, REG_CTRL = 2, REG_CLR = 3.
- One natural sub-module: vga_pixel_tick_gen, a mod-DIV counter with a synchronous clear and enable, producing pixel_tick.

Test Plan:
- Reset held low 3 clks, then released -> x = y = 0, hsync = vsync = 1, frame_count = 0; first pixel_tick on the 4th clk, with frame_start = 1 in that cycle.
- Run 800*4 clks -> x = 0, y = 1. hsync low exactly for x = 656..751, i.e. 96 ticks = 384 clks, aligned to the x change.
- Run one full frame, 1,680,000 clks -> frame_count = 1 and frame_start pulsed exactly once. vsync low only for y = 490..491 (1600 ticks). video_on high for 307,200 ticks.
- At x = 100, y = 5, write reg 2 = 0 -> next clk x = y = 0, pixel_tick stays 0 for 1000 clks. Then write reg 2 = 1 -> tick after 4 clks with frame_start = 1; reg 2 reads 4'b1111 -> 4'b1011 as video_on tracks.
- Write reg 3 in the exact cycle of frame end with frame_count = 7 -> frame_count = 0; reg 0 reads 0.
- Drive reset = 0 for 1 clk at x = 300, y = 200 -> next clk all state reset, run = 1, reg 1 reads 0.
